// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: funct3 encodings, the address-unit
// element consumed by the LSU, FSM state encoding and the CDB lane index.
// Also provides the misalignment predicate used by the optional check.
package load_store_unit_pkg;

  localparam int ROB_IDX_W    = 4;
  localparam int LSU_CDB_LANE = 3;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BCAST = 2'd2,
    DRAIN = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [ROB_IDX_W-1:0] ROB_dest;
    logic [2:0]           funct_3;
    mem_op_t              mem_op;
  } address_buffer_element_t;

  // funct_3[1:0] encodes access size for both loads and stores:
  // 00 byte, 01 half, 1x word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    is_misaligned = ((f3[1:0] == 2'b01) && off[0]) || (f3[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_mem_align.sv
// Combinational lane alignment shared by the LSU and the store buffer.
// Ports: funct_3/offset select size and lane; store_data -> wdata/byte_enable,
// rdata -> load_data (shifted down by offset, then sign/zero-extended).
module load_store_unit_mem_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct_3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_enable,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};

    // 4-bit shift drops any lanes pushed past lane 3.
    case (funct_3[1:0])
      2'b00: begin
        byte_enable = 4'b0001 << offset;
        wdata       = {4{store_data[7:0]}};
      end
      2'b01: begin
        byte_enable = 4'b0011 << offset;
        wdata       = {2{store_data[15:0]}};
      end
      default: begin
        byte_enable = 4'b1111;
        wdata       = store_data;
      end
    endcase

    case (funct_3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {24'h0, shifted[7:0]};
      F3_LHU:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage LSU: accepts one op, issues a single-outstanding dcache request,
// then broadcasts the load result / store completion on its CDB lane.
// Ports: vld_i/rdy_i/address_data_i upstream; dmem_* cache side; cdb_* result lane.
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned half/word ops skip the cache
// and broadcast with cdb_exc_o=1; otherwise cdb_exc_o is tied low.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ROB_IDX_LEN = ROB_IDX_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    fls_i,
  input  logic                                    vld_i,
  output logic                                    rdy_i,
  input  logic [$bits(address_buffer_element_t)-1:0] address_data_i,
  output logic                                    dmem_read,
  output logic                                    dmem_write,
  output logic [31:0]                             dmem_address,
  output logic [31:0]                             dmem_wdata,
  output logic [3:0]                              dmem_byte_enable,
  input  logic [31:0]                             dmem_rdata,
  input  logic                                    dmem_resp,
  output logic                                    cdb_vld_o,
  input  logic                                    cdb_rdy_i,
  output logic [ROB_IDX_LEN-1:0]                  cdb_rob_dest_o,
  output logic [31:0]                             cdb_data_o,
  output logic                                    cdb_exc_o
);

  address_buffer_element_t elem;
  lsu_state_t              state;
  logic [2:0]              lat_f3;
  logic [1:0]              lat_off;
  mem_op_t                 lat_op;
  logic [2:0]              al_f3;
  logic [1:0]              al_off;
  logic [3:0]              al_be;
  logic [31:0]             al_wdata;
  logic [31:0]             al_load;
  logic                    misalign;

  assign elem = address_data_i;

  // In IDLE the aligner formats the incoming op; afterwards it formats rdata
  // for the latched op.
  assign al_f3  = (state == IDLE) ? elem.funct_3   : lat_f3;
  assign al_off = (state == IDLE) ? elem.addr[1:0] : lat_off;

  load_store_unit_mem_align u_align (
    .funct_3     (al_f3),
    .offset      (al_off),
    .store_data  (elem.data),
    .rdata       (dmem_rdata),
    .byte_enable (al_be),
    .wdata       (al_wdata),
    .load_data   (al_load)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(elem.funct_3, elem.addr[1:0]);
`else
  assign misalign  = 1'b0;
  assign cdb_exc_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      rdy_i            <= 1'b0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      cdb_vld_o        <= 1'b0;
      cdb_rob_dest_o   <= '0;
      cdb_data_o       <= '0;
      lat_f3           <= '0;
      lat_off          <= '0;
      lat_op           <= MEM_LOAD;
`ifdef LSU_MISALIGN_CHECK_EN
      cdb_exc_o        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rdy_i <= 1'b1;
          // A flush in the accept cycle drops the element.
          if (!fls_i && vld_i && rdy_i) begin
            rdy_i          <= 1'b0;
            lat_f3         <= elem.funct_3;
            lat_off        <= elem.addr[1:0];
            lat_op         <= elem.mem_op;
            cdb_rob_dest_o <= ROB_IDX_LEN'(elem.ROB_dest);
            if (misalign) begin
              state      <= BCAST;
              cdb_vld_o  <= 1'b1;
              cdb_data_o <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
              cdb_exc_o  <= 1'b1;
`endif
            end else begin
              state            <= REQ;
              dmem_read        <= (elem.mem_op == MEM_LOAD);
              dmem_write       <= (elem.mem_op == MEM_STORE);
              dmem_address     <= {elem.addr[31:2], 2'b00};
              dmem_wdata       <= al_wdata;
              dmem_byte_enable <= al_be;
            end
          end
        end
        REQ: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (fls_i) begin
              state <= IDLE;
              rdy_i <= 1'b1;
            end else begin
              state      <= BCAST;
              cdb_vld_o  <= 1'b1;
              cdb_data_o <= (lat_op == MEM_LOAD) ? al_load : 32'h0;
            end
          end else if (fls_i) begin
            // The cache cannot cancel; wait out the response silently.
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            state      <= IDLE;
            rdy_i      <= 1'b1;
          end
        end
        BCAST: begin
          if (fls_i || cdb_rdy_i) begin
            state     <= IDLE;
            cdb_vld_o <= 1'b0;
            rdy_i     <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
            cdb_exc_o <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus a short
// random sequence; CDB results are checked against a scoreboard queue.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, fls_i, vld_i, rdy_i;
  logic [$bits(address_buffer_element_t)-1:0] address_data_i;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_enable;
  logic        cdb_vld_o, cdb_rdy_i, cdb_exc_o;
  logic [3:0]  cdb_rob_dest_o;
  logic [31:0] cdb_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] data;
    logic        exc;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.ROB_IDX_LEN(4)) dut (
    .clk(clk), .rst(rst), .fls_i(fls_i), .vld_i(vld_i), .rdy_i(rdy_i),
    .address_data_i(address_data_i),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .cdb_vld_o(cdb_vld_o), .cdb_rdy_i(cdb_rdy_i), .cdb_rob_dest_o(cdb_rob_dest_o),
    .cdb_data_o(cdb_data_o), .cdb_exc_o(cdb_exc_o)
  );

  // Scoreboard: every CDB handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst && cdb_vld_o && cdb_rdy_i && !fls_i) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL cdb_unexpected: got rob=%0d data=%h, required no broadcast", cdb_rob_dest_o, cdb_data_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (cdb_rob_dest_o !== e.rob || cdb_data_o !== e.data || cdb_exc_o !== e.exc) begin
          n_fail++;
          $display("FAIL cdb_result: got rob=%0d data=%h exc=%b, required rob=%0d data=%h exc=%b",
                   cdb_rob_dest_o, cdb_data_o, cdb_exc_o, e.rob, e.data, e.exc);
        end
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*off +: 8];
    h = (off == 2'd3) ? {8'h00, rd[31:24]} : rd[8*off +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return rd >> (8*off);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and wait (bounded) for acceptance; optionally push the expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] rob,
                      input logic [2:0] f3, input mem_op_t op, input bit push,
                      input logic [31:0] exp_data, input logic exp_exc);
    address_buffer_element_t e;
    bit ok;
    e.addr = a; e.data = d; e.ROB_dest = rob; e.funct_3 = f3; e.mem_op = op;
    address_data_i = e;
    vld_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rdy_i) begin
        ok = 1'b1;
        if (push) sb_q.push_back('{rob, exp_data, exp_exc});
        step();
        break;
      end
      step();
    end
    vld_i = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout: rdy_i never 1 for rob=%0d, required acceptance within 20 cycles", rob);
    end
  endtask

  task automatic cache_resp(input int delay, input logic [31:0] rd);
    for (int i = 0; i < delay; i++) step();
    dmem_rdata = rd;
    dmem_resp  = 1'b1;
    step();
    dmem_resp  = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rdy_i) begin ok = 1'b1; break; end
      step();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL idle_timeout: rdy_i=%b, required 1 within 20 cycles", rdy_i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fls_i = 0; vld_i = 0; dmem_resp = 0; dmem_rdata = 0; cdb_rdy_i = 1; address_data_i = '0;
    step(); step(); step();
    n_checks++;
    if ({rdy_i, dmem_read, dmem_write, cdb_vld_o, cdb_exc_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 00000", {rdy_i, dmem_read, dmem_write, cdb_vld_o, cdb_exc_o});
    end
    n_checks++;
    if (dmem_address !== 0 || dmem_wdata !== 0 || cdb_data_o !== 0 || dmem_byte_enable !== 0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h wdata=%h cdb=%h be=%b, required all 0",
                         dmem_address, dmem_wdata, cdb_data_o, dmem_byte_enable);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (rdy_i !== 1'b1) begin n_fail++; $display("FAIL reset_exit_rdy: got %b, required 1", rdy_i); end
  endtask

  task automatic test_load_word();
    send(32'h100, 32'h0, 4'd5, 3'b010, MEM_LOAD, 1, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dmem_read !== 1 || dmem_write !== 0 || dmem_address !== 32'h100 || dmem_byte_enable !== 4'hF || rdy_i !== 0) begin
        n_fail++; $display("FAIL lw_req: got rd=%b wr=%b addr=%h be=%h rdy=%b, required 1 0 00000100 f 0",
                           dmem_read, dmem_write, dmem_address, dmem_byte_enable, rdy_i);
      end
      step();
    end
    cache_resp(0, 32'hDEADBEEF);
    n_checks++;
    if (cdb_vld_o !== 1 || cdb_data_o !== 32'hDEADBEEF || cdb_rob_dest_o !== 4'd5 || dmem_read !== 0) begin
      n_fail++; $display("FAIL lw_bcast: got vld=%b data=%h rob=%0d rd=%b, required 1 deadbeef 5 0",
                         cdb_vld_o, cdb_data_o, cdb_rob_dest_o, dmem_read);
    end
    step();
    n_checks++;
    if (rdy_i !== 1 || cdb_vld_o !== 0) begin
      n_fail++; $display("FAIL lw_return_idle: got rdy=%b vld=%b, required 1 0", rdy_i, cdb_vld_o);
    end
  endtask

  task automatic test_load_format();
    logic [31:0] t_addr [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h104};
    logic [2:0]  t_f3   [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b011};
    logic [31:0] t_rd   [5] = '{32'h80000000, 32'h80000000, 32'h80010000, 32'h00008000, 32'h13579BDF};
    logic [31:0] t_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00008001, 32'hFFFF8000, 32'h13579BDF};
    logic [3:0]  t_be   [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      send(t_addr[i], 32'h0, 4'(i + 1), t_f3[i], MEM_LOAD, 1, t_exp[i], 1'b0);
      n_checks++;
      if (dmem_byte_enable !== t_be[i] || dmem_address !== {t_addr[i][31:2], 2'b00} || dmem_read !== 1) begin
        n_fail++; $display("FAIL ld_fmt_req[%0d]: got be=%b addr=%h rd=%b, required be=%b", i,
                           dmem_byte_enable, dmem_address, dmem_read, t_be[i]);
      end
      cache_resp(i % 3, t_rd[i]);
      wait_idle();
    end
  endtask

  task automatic test_store();
    send(32'h202, 32'h1234ABCD, 4'd9, 3'b001, MEM_STORE, 1, 32'h0, 1'b0);
    n_checks++;
    if (dmem_write !== 1 || dmem_read !== 0 || dmem_address !== 32'h200 || dmem_byte_enable !== 4'b1100 || dmem_wdata !== 32'hABCDABCD) begin
      n_fail++; $display("FAIL sh_req: got wr=%b rd=%b addr=%h be=%b wdata=%h, required 1 0 00000200 1100 abcdabcd",
                         dmem_write, dmem_read, dmem_address, dmem_byte_enable, dmem_wdata);
    end
    cache_resp(1, 32'hFFFFFFFF);
    wait_idle();
    send(32'h301, 32'hCAFE12EF, 4'd10, 3'b000, MEM_STORE, 1, 32'h0, 1'b0);
    n_checks++;
    if (dmem_byte_enable !== 4'b0010 || dmem_wdata !== 32'hEFEFEFEF || dmem_address !== 32'h300) begin
      n_fail++; $display("FAIL sb_req: got be=%b wdata=%h addr=%h, required 0010 efefefef 00000300",
                         dmem_byte_enable, dmem_wdata, dmem_address);
    end
    cache_resp(0, 32'h0);
    wait_idle();
  endtask

  task automatic test_flush_req();
    send(32'h400, 32'h0, 4'd3, 3'b010, MEM_LOAD, 0, 32'h0, 1'b0);
    fls_i = 1'b1;
    step();
    fls_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dmem_read !== 1 || rdy_i !== 0 || cdb_vld_o !== 0 || dmem_address !== 32'h400) begin
        n_fail++; $display("FAIL drain_hold: got rd=%b rdy=%b vld=%b addr=%h, required 1 0 0 00000400",
                           dmem_read, rdy_i, cdb_vld_o, dmem_address);
      end
      step();
    end
    cache_resp(0, 32'h11111111);
    n_checks++;
    if (dmem_read !== 0 || cdb_vld_o !== 0 || rdy_i !== 1) begin
      n_fail++; $display("FAIL drain_exit: got rd=%b vld=%b rdy=%b, required 0 0 1", dmem_read, cdb_vld_o, rdy_i);
    end
    send(32'h404, 32'h0, 4'd4, 3'b010, MEM_LOAD, 1, 32'h22222222, 1'b0);
    cache_resp(0, 32'h22222222);
    wait_idle();
  endtask

  task automatic test_cdb_stall();
    cdb_rdy_i = 1'b0;
    send(32'h108, 32'h0, 4'd7, 3'b010, MEM_LOAD, 1, 32'h55AA1234, 1'b0);
    cache_resp(1, 32'h55AA1234);
    dmem_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (cdb_vld_o !== 1 || cdb_data_o !== 32'h55AA1234 || cdb_rob_dest_o !== 4'd7 || rdy_i !== 0) begin
        n_fail++; $display("FAIL cdb_stall[%0d]: got vld=%b data=%h rob=%0d rdy=%b, required 1 55aa1234 7 0",
                           i, cdb_vld_o, cdb_data_o, cdb_rob_dest_o, rdy_i);
      end
      step();
    end
    cdb_rdy_i = 1'b1;
    step();
    n_checks++;
    if (cdb_vld_o !== 0 || rdy_i !== 1) begin
      n_fail++; $display("FAIL cdb_stall_release: got vld=%b rdy=%b, required 0 1", cdb_vld_o, rdy_i);
    end
  endtask

  task automatic test_flush_bcast();
    cdb_rdy_i = 1'b0;
    send(32'h500, 32'h0, 4'd6, 3'b010, MEM_LOAD, 0, 32'h0, 1'b0);
    cache_resp(0, 32'h33333333);
    fls_i = 1'b1;
    step();
    fls_i = 1'b0;
    n_checks++;
    if (cdb_vld_o !== 0 || rdy_i !== 1) begin
      n_fail++; $display("FAIL flush_bcast: got vld=%b rdy=%b, required 0 1", cdb_vld_o, rdy_i);
    end
    cdb_rdy_i = 1'b1;
  endtask

  task automatic test_flush_idle_drop();
    address_buffer_element_t e;
    e.addr = 32'h600; e.data = 0; e.ROB_dest = 4'd8; e.funct_3 = 3'b010; e.mem_op = MEM_LOAD;
    address_data_i = e;
    vld_i = 1'b1;
    fls_i = 1'b1;
    step();
    vld_i = 1'b0;
    fls_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dmem_read !== 0 || dmem_write !== 0 || rdy_i !== 1 || cdb_vld_o !== 0) begin
        n_fail++; $display("FAIL flush_idle_drop: got rd=%b wr=%b rdy=%b vld=%b, required 0 0 1 0",
                           dmem_read, dmem_write, rdy_i, cdb_vld_o);
      end
      step();
    end
  endtask

`ifdef LSU_MISALIGN_CHECK_EN
  task automatic test_misalign();
    send(32'h101, 32'h0, 4'd2, 3'b010, MEM_LOAD, 1, 32'h0, 1'b1);
    n_checks++;
    if (dmem_read !== 0 || cdb_vld_o !== 1 || cdb_exc_o !== 1 || cdb_data_o !== 0) begin
      n_fail++; $display("FAIL misalign_exc: got rd=%b vld=%b exc=%b data=%h, required 0 1 1 0",
                         dmem_read, cdb_vld_o, cdb_exc_o, cdb_data_o);
    end
    wait_idle();
  endtask
`else
  task automatic test_unaligned_default();
    send(32'h103, 32'h0, 4'd11, 3'b001, MEM_LOAD, 1, 32'h00000080, 1'b0);
    n_checks++;
    if (dmem_read !== 1 || dmem_byte_enable !== 4'b1000 || dmem_address !== 32'h100) begin
      n_fail++; $display("FAIL unaligned_lh_req: got rd=%b be=%b addr=%h, required 1 1000 00000100",
                         dmem_read, dmem_byte_enable, dmem_address);
    end
    cache_resp(0, 32'h80000000);
    wait_idle();
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      mem_op_t     op;
      logic [1:0]  size, off;
      logic [2:0]  f3;
      logic [31:0] a, d, rd, expd;
      logic [3:0]  be;
      op   = mem_op_t'($urandom_range(1, 0));
      size = 2'($urandom_range(2, 0));
      off  = (size == 0) ? 2'($urandom_range(3, 0)) : (size == 1) ? {1'($urandom_range(1, 0)), 1'b0} : 2'b00;
      f3   = {(op == MEM_LOAD && size != 2) ? 1'($urandom_range(1, 0)) : 1'b0, size};
      a    = {$urandom_range(32'hFFFF, 0), 14'h0, off};
      d    = $urandom;
      rd   = $urandom;
      be   = (size == 0) ? 4'b0001 << off : (size == 1) ? 4'b0011 << off : 4'b1111;
      expd = (op == MEM_LOAD) ? ref_load(f3, off, rd) : 32'h0;
      send(a, d, 4'(i), f3, op, 1, expd, 1'b0);
      n_checks++;
      if (dmem_byte_enable !== be || dmem_read !== (op == MEM_LOAD) || dmem_write !== (op == MEM_STORE)) begin
        n_fail++; $display("FAIL b2b_req[%0d]: got be=%b rd=%b wr=%b, required be=%b op=%0d",
                           i, dmem_byte_enable, dmem_read, dmem_write, be, op);
      end
      cache_resp(int'($urandom_range(3, 0)), rd);
      wait_idle();
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_format();
    test_store();
    test_flush_req();
    test_cdb_stall();
    test_flush_bcast();
    test_flush_idle_drop();
`ifdef LSU_MISALIGN_CHECK_EN
    test_misalign();
`else
    test_unaligned_default();
`endif
    test_back_to_back();
    step(); step();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
